// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the gated-window frequency meter.
package freq_meter_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  // One-second window at the 50 MHz system clock.
  localparam int unsigned GATE_CYCLES_50MHZ = 50_000_000;

endpackage

// File: rtl/freq_meter_if.sv
// Control and result bundle between the frequency meter and its user.
interface freq_meter_if #(
  parameter int CNT_W = 32
);
  logic             en;
  logic             start;
  logic             sig_in;
  logic [CNT_W-1:0] freq_out;
  logic             valid;
  logic             busy;
  logic             overflow;

  modport master (
    output en, start, sig_in,
    input  freq_out, valid, busy, overflow
  );

  modport slave (
    input  en, start, sig_in,
    output freq_out, valid, busy, overflow
  );
endinterface

// File: rtl/freq_meter_sync_edge_det.sv
// Synchronizes an asynchronous input and flags its rising edges, with the
// first few cycles after reset masked so a level already high is not an edge.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic sig_in,
  output logic rise
);

  localparam int MASK_W = $clog2(SYNC_STAGES + 2);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [MASK_W-1:0]      mask_cnt;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      prev_q   <= 1'b0;
      mask_cnt <= MASK_W'(SYNC_STAGES + 1);
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      prev_q <= sync_q[SYNC_STAGES-1];
      if (mask_cnt != '0) mask_cnt <= mask_cnt - 1'b1;
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q & (mask_cnt == '0);

endmodule

// File: rtl/freq_meter.sv
// Gated-window frequency meter: counts sig_in rising edges over GATE_CYCLES clocks.
//   state   | meaning
//   IDLE    | counters cleared, waiting for en or start
//   MEASURE | window running; gate_cnt counts cycles, edge_cnt counts edges
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = GATE_CYCLES_50MHZ,
  parameter int          CNT_W       = 32,
  parameter int          SYNC_STAGES = 2
) (
  input logic        clk_in,
  input logic        rst_n,
  freq_meter_if.slave bus
);

  localparam int              GATE_W    = $clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  state_t             state_q, state_d;
  logic [GATE_W-1:0]  gate_cnt;
  logic [CNT_W-1:0]   edge_cnt, edge_next;
  logic               sat_q, sat_next;
  logic               oneshot_q;
  logic               rise, done;
  logic [CNT_W-1:0]   freq_q;
  logic               valid_q, ovf_q;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .sig_in (bus.sig_in),
    .rise   (rise)
  );

  always_comb begin
    state_d   = state_q;
    done      = 1'b0;
    edge_next = (rise && !(&edge_cnt)) ? edge_cnt + 1'b1 : edge_cnt;
    sat_next  = sat_q | (rise & (&edge_cnt));
    case (state_q)
      IDLE: begin
        if (bus.en || bus.start) state_d = MEASURE;
      end
      MEASURE: begin
        // Completion wins over abort so a finished window is never discarded.
        if (gate_cnt == GATE_LAST) begin
          done    = 1'b1;
          state_d = bus.en ? MEASURE : IDLE;
        end else if (!bus.en && !oneshot_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gate_cnt  <= '0;
      edge_cnt  <= '0;
      sat_q     <= 1'b0;
      oneshot_q <= 1'b0;
      freq_q    <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= done;
      if (done) begin
        freq_q <= edge_next;
        ovf_q  <= sat_next;
      end
      if (state_q == MEASURE && !done) begin
        gate_cnt <= gate_cnt + 1'b1;
        edge_cnt <= edge_next;
        sat_q    <= sat_next;
      end else begin
        gate_cnt <= '0;
        edge_cnt <= '0;
        sat_q    <= 1'b0;
      end
      if (state_q == IDLE && state_d == MEASURE) oneshot_q <= !bus.en;
      else if (done)                             oneshot_q <= 1'b0;
    end
  end

  assign bus.freq_out = freq_q;
  assign bus.valid    = valid_q;
  assign bus.busy     = (state_q == MEASURE);
  assign bus.overflow = ovf_q;

endmodule

// File: doc/freq_meter.md
# freq_meter

Gated-window frequency meter: counts rising edges of an asynchronous input `sig_in` over a fixed window of `GATE_CYCLES` system clocks and reports the count. It is the measuring counterpart of the board's clock dividers. It checks divider outputs and external pulse sources against the 50 MHz system clock. Supports continuous back-to-back windows and single-shot measurements.

## Interface
- `GATE_CYCLES`, default 50000000: window length in `clk_in` cycles (1 s at 50 MHz); must be ≥ 2.
- `CNT_W`, default 32: width of the edge counter and of `freq_out`.
- `SYNC_STAGES`, default 2: synchronizer depth for `sig_in`; must be ≥ 2.

- `clk_in`  in  1  system clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  continuous mode; while high, windows run back-to-back.
- `start`  in  1  single-shot request, sampled in IDLE only.
- `sig_in`  in  1  asynchronous signal under measurement.
- `freq_out`  out  CNT_W  edge count of the last completed window; held until the next completion.
- `valid`  out  1  one-cycle pulse when `freq_out`/`overflow` update.
- `busy`  out  1  high while a window is in progress.
- `overflow`  out  1  set if the last window's count saturated; updated with `freq_out`.

## Operation
- Input path: `sig_in` → SYNC_STAGES-flop synchronizer → previous-value register. An edge is detected when the synchronized value is 1 and the previous value is 0.
- Edge detection is masked for the first SYNC_STAGES+1 cycles after reset release. This prevents a false edge when `sig_in` is high at reset.
- States:
  - IDLE: counters are cleared. `en`=1 or `start`=1 → MEASURE.
  - MEASURE: `gate_cnt` increments every cycle. `edge_cnt` increments on each detected edge and saturates at 2^CNT_W−1.
- On the last window cycle (`gate_cnt` = GATE_CYCLES−1):
  - Latch `freq_out` = `edge_cnt` + (edge this cycle), saturated.
  - Set `overflow` if the increment would have exceeded the maximum.
  - Assert `valid` next cycle.
  - Then, if `en`=1: restart immediately with `gate_cnt`=0 and `edge_cnt`=0. There are no dead cycles and no lost edges.
  - Otherwise go to IDLE.
- `en` falling during MEASURE aborts the window:
  - Return to IDLE next cycle.
  - No `valid`; `freq_out`/`overflow` are unchanged.
  - Exception: a single-shot window (entered via `start` with `en`=0) is not affected by `en`.
- `start` during MEASURE is ignored. `start` and `en` high together → continuous mode.
- `busy` = (state == MEASURE).
- Maximum measurable `sig_in` frequency is below `clk_in`/2. Pulses shorter than one `clk_in` period may be missed; this is by design.

## Timing
- Reset: state IDLE, all counters 0, synchronizer flops 0, `freq_out`=0, `valid`=0, `busy`=0, `overflow`=0. Reset mid-window discards the window with no `valid`.
- `busy` rises the cycle after `start`/`en` is sampled in IDLE. The window covers exactly GATE_CYCLES cycles of MEASURE.
- A `sig_in` rising edge is counted SYNC_STAGES+1 cycles after it occurs. Edges detected in the final window cycle belong to that window; edges detected in the next cycle belong to the next window.
- `valid` is high for exactly one cycle. In continuous mode it repeats every GATE_CYCLES cycles.
- Single-shot: `busy` falls in the same cycle `valid` rises.

## Structure
- `freq_meter_pkg`: state enum (IDLE, MEASURE) and the default GATE_CYCLES constant for 50 MHz.
- Sub-module `sync_edge_det` (parameter SYNC_STAGES): synchronizer, previous-value register and post-reset mask; outputs a one-cycle `rise` pulse.
- Top level holds the FSM, gate counter (width $clog2(GATE_CYCLES)), saturating edge counter and output registers.

## Test plan
Bench uses GATE_CYCLES=100 unless noted.
- `en`=1, `sig_in` period 10 clk (50% duty) → `valid` every 100 cycles, `freq_out`=10 every window, `overflow`=0.
- `en`=0, one-cycle `start`, `sig_in` period 4 → `busy` high for exactly 100 cycles, a single `valid` with `freq_out`=25, then IDLE. A second `start` issued during `busy` is ignored.
- CNT_W=4, `en`=1, `sig_in` period 2 → `freq_out`=15, `overflow`=1. Drop the rate to period 10 → next window `freq_out`=10, `overflow`=0.
- `en`=1 to complete one window (`freq_out`=10), then drop `en` at window cycle 50 → no `valid`, `busy` low next cycle, `freq_out` stays 10.
- Pulse `rst_n` low at window cycle 37 → all outputs 0 asynchronously. After release with `en`=1, the first `valid` comes a full 100 cycles after restart.
- `sig_in` held high across reset release, no toggling, `en`=1 → `freq_out`=0 (no false edge).
